// File: rtl/enemy_missile_walker.sv
// enemy_missile_walker: Bresenham walker offering one missile trail pixel per step_tick over a valid/ready plot port.
// Define TRAIL_ERASE_EN to re-walk the finished line in BACK_COLOR before returning to idle.
module enemy_missile_walker #(
    parameter logic [2:0] MISSILE_COLOR = 3'b101
`ifdef TRAIL_ERASE_EN
    , parameter logic [2:0] BACK_COLOR = 3'b000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] x0,
    input  logic [8:0] x1,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    input  logic       step_tick,
    input  logic       abort,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic [2:0] pix_color,
    output logic       busy,
    output logic       impact,
    output logic [8:0] impact_x
);
    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_TICK, PLOT, STEP, ARRIVE
`ifdef TRAIL_ERASE_EN
        , E_LOAD, E_PLOT, E_STEP
`endif
    } state_t;

    state_t state, state_n;
    logic [8:0] x, xa, xb;
    logic [7:0] y, ya, yb;
    logic signed [10:0] dx, dy, err, dx_l, dy_l;
    logic signed [11:0] e2;
    logic sx_neg, sy_neg, pend;
    logic at_end, do_load, do_step, step_x, step_y;

    assign e2     = {err, 1'b0};
    assign step_x = e2 >= $signed({dy[10], dy});
    assign step_y = e2 <= $signed({dx[10], dx});
    assign at_end = (x == xb) && (y == yb);
    assign dx_l   = (xb >= xa) ? $signed({2'b0, xb - xa}) : $signed({2'b0, xa - xb});
    assign dy_l   = (yb >= ya) ? -$signed({3'b0, yb - ya}) : -$signed({3'b0, ya - yb});
    assign pix_x  = x;
    assign pix_y  = y;

`ifdef TRAIL_ERASE_EN
    assign do_load   = state == LOAD || state == E_LOAD;
    assign do_step   = state == STEP || state == E_STEP;
    assign pix_valid = state == PLOT || state == E_PLOT;
    assign pix_color = state == PLOT ? MISSILE_COLOR : state == E_PLOT ? BACK_COLOR : 3'b000;
`else
    assign do_load   = state == LOAD;
    assign do_step   = state == STEP;
    assign pix_valid = state == PLOT;
    assign pix_color = state == PLOT ? MISSILE_COLOR : 3'b000;
`endif

    // abort outranks every transition, including a same-cycle handshake
    always_comb begin
        state_n = state;
        if (abort && state != IDLE)
            state_n = IDLE;
        else
            case (state)
                IDLE:      state_n = start ? LOAD : IDLE;
                LOAD:      state_n = PLOT;
                WAIT_TICK: state_n = pend ? STEP : WAIT_TICK;
                PLOT:      state_n = !pix_ready ? PLOT : at_end ? ARRIVE : WAIT_TICK;
                STEP:      state_n = PLOT;
`ifdef TRAIL_ERASE_EN
                ARRIVE:    state_n = E_LOAD;
                E_LOAD:    state_n = E_PLOT;
                E_PLOT:    state_n = !pix_ready ? E_PLOT : at_end ? IDLE : E_STEP;
                E_STEP:    state_n = E_PLOT;
`endif
                default:   state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            impact   <= 1'b0;
            impact_x <= '0;
            pend     <= 1'b0;
            x        <= '0;
            y        <= '0;
            xa       <= '0;
            ya       <= '0;
            xb       <= '0;
            yb       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
        end else begin
            state  <= state_n;
            busy   <= state_n != IDLE;
            impact <= state_n == ARRIVE;
            // single-depth tick memory; the STEP entry consumes it
            pend   <= state != IDLE && !(state == WAIT_TICK && pend) && (pend || step_tick);
            if (state_n == ARRIVE)
                impact_x <= xb;
            if (state == IDLE && start) begin
                xa <= x0;
                ya <= y0;
                xb <= x1;
                yb <= y1;
            end
            if (do_load) begin
                x      <= xa;
                y      <= ya;
                sx_neg <= xb < xa;
                sy_neg <= yb < ya;
                dx     <= dx_l;
                dy     <= dy_l;
                err    <= dx_l + dy_l;
            end
            if (do_step) begin
                err <= err + (step_x ? dy : 11'sd0) + (step_y ? dx : 11'sd0);
                if (step_x)
                    x <= sx_neg ? x - 9'd1 : x + 9'd1;
                if (step_y)
                    y <= sy_neg ? y - 8'd1 : y + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_enemy_missile_walker.sv
// tb_enemy_missile_walker: table-driven, hand-written and randomized missile walks checked against
// a Bresenham reference model of the expected trail.
module tb_enemy_missile_walker;
    localparam int MC = 5;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, step_tick = 1'b0, abort = 1'b0, pix_ready = 1'b0;
    logic [8:0] x0 = '0, x1 = '0;
    logic [7:0] y0 = '0, y1 = '0;
    logic       pix_valid, busy, impact;
    logic [8:0] pix_x, impact_x;
    logic [7:0] pix_y;
    logic [2:0] pix_color;
    int errs = 0, checks = 0;

    enemy_missile_walker dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .step_tick(step_tick), .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .busy(busy), .impact(impact),
        .impact_x(impact_x)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int x; int y;} pt_t;
    pt_t exp_q[$];

    // Expected trail from the line-drawing rule, using plain integers
    function automatic void model(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_q.delete();
        dx  = bx > ax ? bx - ax : ax - bx;
        dy  = by > ay ? ay - by : by - ay;
        sx  = bx >= ax ? 1 : -1;
        sy  = by >= ay ? 1 : -1;
        err = dx + dy;
        x   = ax;
        y   = ay;
        for (int k = 0; k < 1000; k++) begin
            exp_q.push_back('{x: x, y: y});
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic run_walk(input int ax, input int ay, input int bx, input int by, input int tp,
                            input bit rr, output int n, output int lx, output int ly);
        int idx = 0, imp = 0, j;
        bit seen = 0, done = 0, stall = 0;
        logic [19:0] held = '0;
        model(ax, ay, bx, by);
        lx = -1;
        ly = -1;
        @(negedge clk);
        x0 = 9'(ax); y0 = 8'(ay); x1 = 9'(bx); y1 = 8'(by);
        start = 1'b1; pix_ready = 1'b1; step_tick = 1'b0;
        @(negedge clk);
        x0 = 9'($urandom_range(319)); y0 = 8'($urandom_range(239));
        x1 = 9'($urandom_range(319)); y1 = 8'($urandom_range(239));
        for (int c = 0; c < 4000 && !done; c++) begin
            if (stall) chk("stall_hold", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, held});
            if (impact) begin
                imp++;
                chk("impact_x", impact_x, bx);
                chk("impact_after_last", idx, exp_q.size());
            end
            if (busy) seen = 1; else if (seen) done = 1;
            start     = done ? 1'b0 : 1'($urandom_range(1));
            step_tick = tp > 0 ? (c % tp == 0) : ($urandom_range(3) == 0);
            pix_ready = rr ? ($urandom_range(9) < 7) : 1'b1;
            stall     = pix_valid && !pix_ready;
            held      = {pix_x, pix_y, pix_color};
            if (pix_valid && pix_ready) begin
                j = imp > 0 ? idx - exp_q.size() : idx;
                if (j >= 0 && j < exp_q.size()) begin
                    chk("pix_x", pix_x, exp_q[j].x);
                    chk("pix_y", pix_y, exp_q[j].y);
                    chk("pix_color", pix_color, imp > 0 ? 0 : MC);
                end else chk("extra_pixel", idx, exp_q.size());
                if (imp == 0) begin lx = pix_x; ly = pix_y; end
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0; step_tick = 1'b0; pix_ready = 1'b1;
        chk("walk_done", int'(done), 1);
`ifdef TRAIL_ERASE_EN
        chk("pix_count", idx, 2 * exp_q.size());
`else
        chk("pix_count", idx, exp_q.size());
`endif
        chk("impact_count", imp, 1);
        n = imp > 0 ? idx - (idx - exp_q.size()) * int'(idx > exp_q.size()) : idx;
    endtask

    typedef struct {int ax; int ay; int bx; int by; int n; int ex; int ey; int tp; int rr;} vec_t;
    vec_t tbl[6];

    initial begin
        int n, lx, ly, cnt, imp, v, ax, ay, bx, by;
        bit hit;
        tbl[0] = '{64, 0, 64, 3, 4, 64, 3, 5, 0};
        tbl[1] = '{0, 0, 3, 3, 4, 3, 3, 5, 0};
        tbl[2] = '{10, 5, 14, 7, 5, 14, 7, 5, 0};
        tbl[3] = '{5, 5, 5, 5, 1, 5, 5, 5, 0};
        tbl[4] = '{20, 100, 0, 90, 21, 0, 90, 0, 1};
        tbl[5] = '{300, 239, 310, 200, 40, 310, 200, 3, 1};

        repeat (2) @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        chk("rst_color", pix_color, 0);
        chk("rst_busy", busy, 0);
        chk("rst_impact", impact, 0);
        chk("rst_impact_x", impact_x, 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_walk(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].tp, tbl[i].rr[0], n, lx, ly);
            chk("tbl_count", n, tbl[i].n);
            chk("tbl_last_x", lx, tbl[i].ex);
            chk("tbl_last_y", ly, tbl[i].ey);
        end

        // backpressure with ticks piling up during a stall
        @(negedge clk);
        x0 = 9'd64; y0 = 8'd0; x1 = 9'd64; y1 = 8'd3; start = 1'b1; pix_ready = 1'b1; step_tick = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("bp_load_no_valid", pix_valid, 0);
        @(negedge clk);
        chk("bp_first", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 9'd64, 8'd0, 3'd5});
        @(negedge clk);
        chk("bp_after_xfer", pix_valid, 0);
        step_tick = 1'b1;
        @(negedge clk); step_tick = 1'b0;
        @(negedge clk); pix_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_stall", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 9'd64, 8'd1, 3'd5});
            step_tick = (k == 2 || k == 5 || k == 8);
        end
        step_tick = 1'b0; pix_ready = 1'b1;
        @(negedge clk); chk("bp_t1", pix_valid, 0);
        @(negedge clk); chk("bp_t2", pix_valid, 0);
        @(negedge clk);
        chk("bp_t3", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 9'd64, 8'd2, 3'd5});
        v = 0;
        repeat (5) begin @(negedge clk); v += int'(pix_valid); end
        chk("bp_tick_dropped", v, 0);
        step_tick = 1'b1; imp = 0;
        for (int c = 0; c < 80 && busy; c++) begin
            if (impact) begin imp++; chk("bp_impact_x", impact_x, 64); end
            @(negedge clk);
        end
        step_tick = 1'b0;
        chk("bp_impact_count", imp, 1);
        chk("bp_busy_fell", busy, 0);

        // abort together with pix_ready on the third pixel
        @(negedge clk);
        x0 = 9'd0; y0 = 8'd0; x1 = 9'd10; y1 = 8'd0; start = 1'b1; pix_ready = 1'b1; step_tick = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0; hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            if (pix_valid) begin
                if (cnt == 2) begin hit = 1; abort = 1'b1; end else cnt++;
            end
            if (!hit) @(negedge clk);
        end
        chk("abort_reached", int'(hit), 1);
        chk("abort_third_x", pix_x, 2);
        @(negedge clk); abort = 1'b0; step_tick = 1'b0;
        chk("abort_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        imp = 0; v = 0;
        repeat (6) begin imp += int'(impact); v += int'(pix_valid); @(negedge clk); end
        chk("abort_no_impact", imp, 0);
        chk("abort_stays_idle", v, 0);

        // asynchronous reset while in STEP
        x0 = 9'd100; y0 = 8'd50; x1 = 9'd110; y1 = 8'd50; start = 1'b1; pix_ready = 1'b1; step_tick = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (pix_valid) hit = 1;
            @(negedge clk);
        end
        chk("rstmid_reached", int'(hit), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_valid", pix_valid, 0);
        chk("rstmid_x", pix_x, 0);
        chk("rstmid_y", pix_y, 0);
        chk("rstmid_color", pix_color, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_impact", impact, 0);
        chk("rstmid_impact_x", impact_x, 0);
        @(negedge clk); rst = 1'b1; step_tick = 1'b0;
        v = 0;
        repeat (3) begin @(negedge clk); v += int'(pix_valid) + int'(busy); end
        chk("rstmid_quiet", v, 0);
        run_walk(7, 9, 12, 11, 2, 1'b0, n, lx, ly);
        chk("rstmid_new_last", lx * 256 + ly, 12 * 256 + 11);

        for (int i = 0; i < 6; i++) begin
            ax = int'($urandom_range(319));
            ay = int'($urandom_range(239));
            bx = ax + int'($urandom_range(40)) - 20;
            by = ay + int'($urandom_range(40)) - 20;
            bx = bx < 0 ? 0 : bx > 319 ? 319 : bx;
            by = by < 0 ? 0 : by > 239 ? 239 : by;
            run_walk(ax, ay, bx, by, 0, 1'b1, n, lx, ly);
            chk("rnd_last", lx * 256 + ly, bx * 256 + by);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/enemy_missile_walker.md
# enemy_missile_walker

Upstream pixel source for the frame-drawing FSM: walks one enemy missile's trajectory from launch point to target with an integer Bresenham stepper, advancing one pixel per `step_tick`. Each new trail pixel is offered to the drawing FSM over a valid/ready plot handshake (x, y, color). The downstream FSM forwards it to the VGA adapter. On arrival the block reports the impact point so game logic can resolve city hits.

## Interface
- `MISSILE_COLOR`, default 3'b101: color driven on trail pixels.
- `BACK_COLOR`, default 3'b000: color driven on erase pixels (only with `TRAIL_ERASE_EN`).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: launch request, sampled only in IDLE.
- `x0`, `x1` in 9 each: launch and target x, 0–319.
- `y0`, `y1` in 8 each: launch and target y, 0–239.
- `step_tick` in 1: one-cycle pulse, advance permission (frame/speed tick).
- `abort` in 1: kill the missile (intercepted).
- `pix_valid` out 1: plot request valid.
- `pix_ready` in 1: downstream accepts the pixel.
- `pix_x` out 9, `pix_y` out 8, `pix_color` out 3: pixel to plot.
- `busy` out 1: not in IDLE.
- `impact` out 1: one-cycle pulse when the target pixel has been accepted.
- `impact_x` out 9: x of the last impact, held until the next impact.

## Operation
- States: IDLE, LOAD, WAIT_TICK, PLOT, STEP, ARRIVE. Build with `TRAIL_ERASE_EN` also has E_LOAD, E_PLOT, E_STEP.
- IDLE: on `start`=1 → LOAD, registering the endpoints. `start` is ignored in all other states.
- LOAD: compute the step values, then → PLOT with the first pixel = (x0,y0). The first pixel needs no tick.
  - `dx`=|x1−x0|, `dy`=−|y1−y0|, `sx`/`sy`=±1.
  - `err`=dx+dy.
  - Signed 11-bit arithmetic. `e2`=2·err is 12-bit signed.
- PLOT: `pix_valid`=1 with the current (x,y) and `MISSILE_COLOR`. On `pix_valid`&`pix_ready`:
  - if current = (x1,y1) → ARRIVE;
  - otherwise → WAIT_TICK.
- WAIT_TICK: when a tick is pending, clear the pending flag and → STEP.
- STEP: one Bresenham update, then → PLOT.
  - If e2≥dy: err+=dy, x+=sx.
  - If e2≤dx: err+=dx, y+=sy.
  - Both may apply in the same cycle (diagonal).
- ARRIVE: `impact` pulse, `impact_x`←x1, → IDLE. With `TRAIL_ERASE_EN` the next state is E_LOAD instead of IDLE.
- Tick pending flag: single-depth.
  - Set by `step_tick` in any non-IDLE state.
  - Cleared on entry to STEP.
  - Extra ticks while the flag is already set are dropped.
- Degenerate line (x0,y0)=(x1,y1): exactly one pixel is plotted, then ARRIVE.
- `abort`=1 in any non-IDLE state → IDLE on the next edge.
  - `pix_valid` drops on that edge.
  - No `impact` pulse.
  - `abort` has priority over `pix_ready` in the same cycle.
- Coordinates never wrap. Endpoints are in range by contract, and the walk stops exactly at (x1,y1).

## Timing
- Reset values:
  - state IDLE; `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_color`=3'b000;
  - `busy`=0, `impact`=0, `impact_x`=0;
  - err=0; tick pending flag=0.
- `start` edge → `pix_valid` high 2 cycles later (IDLE→LOAD→PLOT).
- Handshake:
  - `pix_x`, `pix_y` and `pix_color` are stable while `pix_valid`=1 and `pix_ready`=0.
  - Transfer happens on the edge with both signals high.
  - `pix_valid` is deasserted the cycle after the transfer.
- Tick already pending at the handshake → next pixel valid 3 cycles after the transfer edge (WAIT_TICK, STEP, PLOT).
- `impact` asserts the cycle after the final transfer, for one cycle.
- `busy` is registered and equals (state≠IDLE).
- Reset mid-operation clears everything asynchronously. No pixel is emitted afterwards.

## Configuration
- `TRAIL_ERASE_EN` defined: after ARRIVE, the block re-walks the same line from (x0,y0).
  - Pixels are emitted in `BACK_COLOR`, one per handshake, with no tick wait.
  - `busy` stays high until the last erase pixel is accepted, then → IDLE.
  - `abort` during the erase walk → IDLE.
- `TRAIL_ERASE_EN` undefined: ARRIVE → IDLE. The E_* states and `BACK_COLOR` logic are not generated.

## Test plan
- Vertical walk. Start (64,0)→(64,3); `pix_ready`=1; one tick every 5 cycles.
  - Pixels (64,0),(64,1),(64,2),(64,3), all color 3'b101.
  - One `impact` pulse; `impact_x`=64; `busy` falls.
- Diagonal and shallow slopes.
  - (0,0)→(3,3) → (0,0),(1,1),(2,2),(3,3).
  - (10,5)→(14,7) → 5 pixels ending at (14,7), x strictly incrementing.
- Backpressure. Hold `pix_ready`=0 for 10 cycles during the second pixel, with 3 ticks arriving meanwhile.
  - Outputs stay stable for the whole stall.
  - Only one pending tick is kept; the following pixel appears 3 cycles after the transfer.
- Control edges.
  - `start` asserted while busy: no effect.
  - `abort` together with `pix_ready` at the third pixel: no transfer counted, no `impact`, IDLE next cycle.
  - Degenerate (5,5)→(5,5): exactly one pixel, then `impact`.
- Reset mid-operation. `rst` low during STEP.
  - All outputs return to their reset values immediately.
  - After release, a new `start` walks from its own x0,y0.
- Erase build (`TRAIL_ERASE_EN`). Walk (64,0)→(64,3).
  - Four pixels in 3'b101, then `impact`.
  - Then the same four coordinates in 3'b000 with no ticks required.
  - `busy` stays high through the erase walk, then IDLE.
